// File: rtl/looper_ctrl.sv
// looper_ctrl: transport controller for the audio loop memory.
// Turns button pulses into record/play/reverse levels, counts loop length.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   sampleTick      one-cycle strobe per audio sample slot
//   recBtn          pulse: start / stop record
//   playBtn         pulse: stop record / play-pause toggle
//   revBtn          pulse: toggle playback direction
//   clearBtn        pulse: discard loop
//   write, read     levels: datapath records / plays back
//   reverse         level: playback runs backwards
//   loopClear       one-cycle pulse clearing the loop datapath
//   loopFull        level: loopLen == LOOP_MAX
//   state           00 EMPTY, 01 RECORD, 10 PLAY, 11 PAUSE
//   loopLen         samples recorded in the current loop
module looper_ctrl #(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sampleTick,
    input  logic                  recBtn,
    input  logic                  playBtn,
    input  logic                  revBtn,
    input  logic                  clearBtn,
    output logic                  write,
    output logic                  read,
    output logic                  reverse,
    output logic                  loopClear,
    output logic                  loopFull,
    output logic [1:0]            state,
    output logic [ADDR_WIDTH-1:0] loopLen
);

    localparam logic [ADDR_WIDTH-1:0] LOOP_MAX = '1;

    typedef enum logic [1:0] {
        S_EMPTY  = 2'b00,
        S_RECORD = 2'b01,
        S_PLAY   = 2'b10,
        S_PAUSE  = 2'b11
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d, len_tick;
    logic                  rev_q, rev_d;
    logic                  clr_q, clr_d, clr_req;
    logic                  full_q, full_d;
    logic                  write_q, write_d;
    logic                  read_q, read_d;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        rev_d    = rev_q;
        clr_req  = 1'b0;
        len_tick = len_q + ADDR_WIDTH'(sampleTick);

        if (clearBtn) begin
            state_d = S_EMPTY;
            len_d   = '0;
            rev_d   = 1'b0;
            clr_req = 1'b1;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (recBtn) begin
                        state_d = S_RECORD;
                        len_d   = '0;
                        rev_d   = 1'b0;
                    end
                end
                S_RECORD: begin
                    // A coincident tick is counted before any stop acts.
                    len_d = len_tick;
                    if (len_tick == LOOP_MAX) begin
                        state_d = S_PLAY;
                    end else if (recBtn || playBtn) begin
                        if (len_tick != '0) begin
                            state_d = S_PLAY;
                        end else begin
                            state_d = S_EMPTY;
                            clr_req = 1'b1;
                        end
                    end
                end
                S_PLAY, S_PAUSE: begin
                    if (recBtn) begin
                        state_d = S_RECORD;
                        len_d   = '0;
                        rev_d   = 1'b0;
                        clr_req = 1'b1;
                    end else if (playBtn) begin
                        state_d = (state_q == S_PLAY) ? S_PAUSE : S_PLAY;
                    end else if (revBtn) begin
                        rev_d = ~rev_q;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end

        // Back-to-back clear requests collapse into a single pulse.
        clr_d   = clr_req & ~clr_q;
        full_d  = (len_d == LOOP_MAX);
        write_d = (state_d == S_RECORD);
        read_d  = (state_d == S_PLAY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            len_q   <= '0;
            rev_q   <= 1'b0;
            clr_q   <= 1'b0;
            full_q  <= 1'b0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            rev_q   <= rev_d;
            clr_q   <= clr_d;
            full_q  <= full_d;
            write_q <= write_d;
            read_q  <= read_d;
        end
    end

    assign state     = state_q;
    assign loopLen   = len_q;
    assign reverse   = rev_q;
    assign loopClear = clr_q;
    assign loopFull  = full_q;
    assign write     = write_q;
    assign read      = read_q;

endmodule

// File: tb/tb_looper_ctrl.sv
// tb_looper_ctrl: scoreboard bench for looper_ctrl (ADDR_WIDTH=4).
// Directed transport scenarios followed by randomized button traffic.
module tb_looper_ctrl;

    localparam int AW   = 4;
    localparam int LMAX = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sampleTick = 1'b0;
    logic          recBtn = 1'b0;
    logic          playBtn = 1'b0;
    logic          revBtn = 1'b0;
    logic          clearBtn = 1'b0;
    logic          write, read, reverse, loopClear, loopFull;
    logic [1:0]    state;
    logic [AW-1:0] loopLen;

    looper_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .sampleTick(sampleTick),
        .recBtn    (recBtn),
        .playBtn   (playBtn),
        .revBtn    (revBtn),
        .clearBtn  (clearBtn),
        .write     (write),
        .read      (read),
        .reverse   (reverse),
        .loopClear (loopClear),
        .loopFull  (loopFull),
        .state     (state),
        .loopLen   (loopLen)
    );

    always #5 clk = ~clk;

    // expected vector: {state, write, read, reverse, loopClear, loopFull, loopLen}
    logic [10:0] exp_q[$];
    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;
    bit done = 0;

    // reference model: mode 0 empty, 1 recording, 2 playing, 3 paused
    int m_mode = 0;
    int m_len  = 0;
    bit m_rev  = 0;
    bit m_clr  = 0;

    task automatic model(input bit rs, input bit t, input bit r,
                         input bit p, input bit v, input bit c);
        bit want;
        want = 0;
        if (rs) begin
            m_mode = 0; m_len = 0; m_rev = 0; m_clr = 0;
        end else begin
            if (c) begin
                m_mode = 0; m_len = 0; m_rev = 0; want = 1;
            end else if (m_mode == 0) begin
                if (r) begin m_mode = 1; m_len = 0; m_rev = 0; end
            end else if (m_mode == 1) begin
                if (t) m_len = m_len + 1;
                if (m_len == LMAX) m_mode = 2;
                else if (r || p) begin
                    if (m_len > 0) m_mode = 2;
                    else begin m_mode = 0; want = 1; end
                end
            end else begin
                if (r) begin
                    m_mode = 1; m_len = 0; m_rev = 0; want = 1;
                end else if (p) m_mode = (m_mode == 2) ? 3 : 2;
                else if (v) m_rev = !m_rev;
            end
            m_clr = want && !m_clr;
        end
    endtask

    function automatic logic [10:0] model_out();
        logic [1:0] s;
        s = 2'(m_mode);
        return {s, m_mode == 1, m_mode == 2, m_rev, m_clr,
                m_len == LMAX, 4'(m_len)};
    endfunction

    task automatic step(input bit rs, input bit t, input bit r,
                        input bit p, input bit v, input bit c);
        reset = rs; sampleTick = t; recBtn = r;
        playBtn = p; revBtn = v; clearBtn = c;
        @(posedge clk);
        model(rs, t, r, p, v, c);
        exp_q.push_back(model_out());
        started = 1;
        #1;
        reset = 0; sampleTick = 0; recBtn = 0;
        playBtn = 0; revBtn = 0; clearBtn = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0);
    endtask

    // monitor: compares every registered output set against the scoreboard
    logic        prev_clr = 0;
    logic [10:0] act, e;
    always @(negedge clk) begin
        act = {state, write, read, reverse, loopClear, loopFull, loopLen};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (act !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got st=%b w=%b r=%b rev=%b clr=%b full=%b len=%0d, want st=%b w=%b r=%b rev=%b clr=%b full=%b len=%0d",
                         $time, act[10:9], act[8], act[7], act[6], act[5], act[4], act[3:0],
                         e[10:9], e[8], e[7], e[6], e[5], e[4], e[3:0]);
            end
        end
        if (started && !done) begin
            n_chk++;
            if (read && write) begin
                n_fail++;
                $display("FAIL rw_excl t=%0t: got read=%b write=%b, want not both", $time, read, write);
            end
            n_chk++;
            if (loopClear && prev_clr) begin
                n_fail++;
                $display("FAIL clr_pulse t=%0t: got loopClear high 2 cycles, want 1", $time);
            end
        end
        prev_clr = loopClear;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        // 1: reset held, then released idle
        repeat (3) step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // 2: record 6, play, pause
        step(0, 0, 1, 0, 0, 0);
        ticks(6);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        // 3: record to capacity with excess ticks
        step(0, 0, 1, 0, 0, 0);
        ticks(20);
        // 4: reverse in play and pause, then re-record
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // 5: empty record stop, then clear beats rec
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        ticks(3);
        step(0, 1, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        // 6: reset mid-record
        step(0, 0, 1, 0, 0, 0);
        ticks(9);
        step(1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 199);
            step(r == 0,
                 $urandom_range(0, 1) == 0,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 29) == 0);
        end
        repeat (2) @(negedge clk);
        done = 1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
